// File: rtl/axi_bresp_monitor.sv
// Passive AXI-Lite B-channel monitor: outstanding-write tracking, sticky protocol-violation flags, error counter.
// Optional per-BRESP response statistics are built when AXI_BMON_STATS_EN is defined.
module axi_bresp_monitor #(
    parameter  int MAXWAIT         = 5,
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int CNT_WIDTH       = 16,
    localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 AXI_ACLK,
    input  logic                 AXI_ARESETN,
    input  logic                 AXI_AWVALID,
    input  logic                 AXI_AWREADY,
    input  logic                 AXI_WVALID,
    input  logic                 AXI_WREADY,
    input  logic                 AXI_BVALID,
    input  logic                 AXI_BREADY,
    input  logic [1:0]           AXI_BRESP,
    input  logic                 err_clr,
    input  logic                 stat_clr,
    output logic [5:0]           err_flags,
    output logic                 err_any,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [OW-1:0]        aw_outstanding,
    output logic [OW-1:0]        w_outstanding,
    output logic [CNT_WIDTH-1:0] cnt_okay,
    output logic [CNT_WIDTH-1:0] cnt_exokay,
    output logic [CNT_WIDTH-1:0] cnt_slverr,
    output logic [CNT_WIDTH-1:0] cnt_decerr
);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
    localparam logic [7:0]    MAXW  = 8'(MAXWAIT);

    logic                 aw_hs, w_hs, b_hs, stall;
    logic                 first_cyc, prev_stall, to_done;
    logic [1:0]           prev_bresp;
    logic [7:0]           wait_cnt;
    logic [OW-1:0]        aw_q, w_q;
    logic [5:0]           flags_q, viol;
    logic [CNT_WIDTH-1:0] err_cnt_q;

    assign aw_hs = AXI_AWVALID & AXI_AWREADY;
    assign w_hs  = AXI_WVALID & AXI_WREADY;
    assign b_hs  = AXI_BVALID & AXI_BREADY;
    assign stall = AXI_BVALID & ~AXI_BREADY;

    // Increment/decrement cancel out; otherwise clamp to [0, MAX_OUTSTANDING].
    function automatic logic [OW-1:0] track(input logic [OW-1:0] cur, input logic inc, input logic dec);
        if (inc && !dec && cur != MAX_O)
            return cur + OW'(1);
        else if (dec && !inc && cur != '0)
            return cur - OW'(1);
        return cur;
    endfunction

    // The first post-reset edge is only checked for BVALID asserted out of reset.
    always_comb begin
        viol    = '0;
        viol[2] = first_cyc & AXI_BVALID;
        if (!first_cyc) begin
            viol[0] = prev_stall & ~AXI_BVALID;
            viol[1] = prev_stall & AXI_BVALID & (AXI_BRESP != prev_bresp);
            viol[3] = stall & (wait_cnt == MAXW) & ~to_done;
            viol[4] = b_hs & ((aw_q == '0) | (w_q == '0));
            viol[5] = (aw_hs & ~b_hs & (aw_q == MAX_O)) | (w_hs & ~b_hs & (w_q == MAX_O));
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            first_cyc  <= 1'b1;
            prev_stall <= 1'b0;
            prev_bresp <= '0;
            wait_cnt   <= '0;
            to_done    <= 1'b0;
            aw_q       <= '0;
            w_q        <= '0;
            flags_q    <= '0;
            err_cnt_q  <= '0;
        end else begin
            first_cyc  <= 1'b0;
            prev_stall <= stall;
            prev_bresp <= AXI_BRESP;
            // to_done keeps the timeout to one event per stall episode while wait_cnt sits at MAXWAIT.
            if (!stall) begin
                wait_cnt <= '0;
                to_done  <= 1'b0;
            end else if (wait_cnt != MAXW) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                to_done  <= 1'b1;
            end
            aw_q <= track(aw_q, aw_hs, b_hs);
            w_q  <= track(w_q, w_hs, b_hs);
            if (err_clr) begin
                flags_q   <= viol;
                err_cnt_q <= (|viol) ? CNT_WIDTH'(1) : '0;
            end else begin
                flags_q <= flags_q | viol;
                if ((|viol) && !(&err_cnt_q))
                    err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign err_flags      = flags_q;
    assign err_any        = |flags_q;
    assign err_count      = err_cnt_q;
    assign aw_outstanding = aw_q;
    assign w_outstanding  = w_q;

`ifdef AXI_BMON_STATS_EN
    logic [3:0][CNT_WIDTH-1:0] stat_q;

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            stat_q <= '0;
        end else if (stat_clr) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (b_hs && AXI_BRESP == 2'(i) && !(&stat_q[i]))
                    stat_q[i] <= stat_q[i] + CNT_WIDTH'(1);
        end
    end

    assign cnt_okay   = stat_q[0];
    assign cnt_exokay = stat_q[1];
    assign cnt_slverr = stat_q[2];
    assign cnt_decerr = stat_q[3];
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign cnt_okay        = '0;
    assign cnt_exokay      = '0;
    assign cnt_slverr      = '0;
    assign cnt_decerr      = '0;
`endif

endmodule

// File: doc/axi_bresp_monitor.md
Name: axi_bresp_monitor

Overview:
- Synthesizable AXI-Lite write-response channel monitor; successor to the assertion-only B-channel checks.
- Sits passively on one AXI-Lite write port (AW, W and B handshakes) and never drives the bus.
- Tracks outstanding writes, flags B-channel protocol violations as sticky error bits with an error counter, and optionally counts response types.
- Usable in silicon (debug/status registers) as well as simulation.

Parameters:
MAXWAIT, 5, max consecutive BVALID&!BREADY stall cycles before timeout error (1..255)
MAX_OUTSTANDING, 4, max accepted AW (and W) handshakes awaiting a B response (1..255)
CNT_WIDTH, 16, width of error and statistics counters (saturating)

Ports:
AXI_ACLK  in  1  clock
AXI_ARESETN  in  1  asynchronous active-low reset
AXI_AWVALID  in  1  write address valid
AXI_AWREADY  in  1  write address ready
AXI_WVALID  in  1  write data valid
AXI_WREADY  in  1  write data ready
AXI_BVALID  in  1  write response valid
AXI_BREADY  in  1  write response ready
AXI_BRESP  in  2  write response code
err_clr  in  1  synchronous clear of err_flags and err_count
stat_clr  in  1  synchronous clear of statistics counters
err_flags  out  6  sticky violation bits (see Behaviour)
err_any  out  1  OR of err_flags
err_count  out  CNT_WIDTH  saturating count of violation events
aw_outstanding  out  OW  AW handshakes not yet answered; OW=$clog2(MAX_OUTSTANDING+1)
w_outstanding  out  OW  W handshakes not yet answered
cnt_okay, cnt_exokay, cnt_slverr, cnt_decerr  out  CNT_WIDTH each  B handshakes per BRESP value

Behaviour:
- Reset (AXI_ARESETN=0, asynchronous): all outputs and internal registers 0; first_cyc register set to 1.
- Handshakes:
  - AW_hs = AWVALID&AWREADY; W_hs = WVALID&WREADY; B_hs = BVALID&BREADY.
  - All sampled on the rising edge of AXI_ACLK.
- Outstanding counters:
  - aw_outstanding += AW_hs, -= B_hs; same for w_outstanding with W_hs.
  - Simultaneous increment and decrement: value unchanged.
  - Counters saturate at MAX_OUTSTANDING and floor at 0; they never wrap.
- Stall tracking:
  - stall = BVALID&!BREADY.
  - Registers prev_stall and prev_bresp are captured each cycle.
  - wait_cnt (8 bit) increments on stall, saturating at MAXWAIT; it clears whenever !stall.
- Violation bits. Each is set in the cycle after the offending edge (1-cycle latency).
  - [0] BVALID_STABLE: prev_stall & !BVALID.
  - [1] BRESP_STABLE: prev_stall & BVALID & (BRESP != prev_bresp).
  - [2] BVALID_RESET: first_cyc & BVALID. first_cyc clears after the first clock edge with reset deasserted.
  - [3] BREADY_MAX_WAIT: stall & (wait_cnt == MAXWAIT), i.e. on the (MAXWAIT+1)th consecutive stall cycle. Flagged once per stall episode; wait_cnt holds at MAXWAIT.
  - [4] UNEXPECTED_B: B_hs while aw_outstanding==0 or w_outstanding==0. A same-cycle AW_hs/W_hs does not satisfy the check. The affected counter stays at 0.
  - [5] OUTSTANDING_OVF: AW_hs with aw_outstanding==MAX_OUTSTANDING and no B_hs; same check for W.
- err_count:
  - +1 per cycle in which at least one new violation is detected, regardless of how many bits are involved.
  - Saturates at all-ones.
- err_clr:
  - Clears err_flags and err_count next edge.
  - If a violation is detected in the same cycle, its bit is set and err_count becomes 1 (set wins).
- err_any: combinational OR of the registered err_flags.
- Reset mid-transaction: all tracking is discarded. The first post-reset cycle is checked only by BVALID_RESET; stability checks are not applied across reset.

Optional Feature:
- Macro: AXI_BMON_STATS_EN.
- Defined:
  - cnt_okay, cnt_exokay, cnt_slverr, cnt_decerr each increment on B_hs with BRESP = 0, 1, 2, 3 respectively.
  - Counters saturate at all-ones.
  - stat_clr clears them next edge; clear wins over a same-cycle increment.
- Not defined:
  - Ports remain, driven constant 0.
  - stat_clr is ignored.
  - No counter flops are synthesized.

Test Plan:
- Reset deasserted with BVALID=1 in the first cycle -> err_flags=6'b000100, err_count=1. BVALID=0 in the first cycle instead -> err_flags=0.
- AW_hs, then W_hs two cycles later, then B_hs with BRESP=2 -> outstanding counters go 1/0, 1/1, 0/0; err_flags=0; cnt_slverr=1 (STATS_EN).
- MAXWAIT=5, BVALID held with BREADY=0 for 6 cycles -> bit3 set one cycle after the 6th stall edge, err_count=1. Stall lasting exactly 5 cycles then BREADY=1 -> no error.
- During a stall, BRESP changes 0->3 -> bit1 set. During a stall, BVALID drops without BREADY -> bit0 set. err_clr pulse -> err_flags=0, err_count=0.
- B_hs with no prior AW/W -> bit4 set, counters stay 0. Five AW_hs and W_hs with no B (MAX_OUTSTANDING=4) -> bit5 set, counters held at 4.
- Simultaneous AW_hs, W_hs, B_hs with outstanding=1/1 -> counters stay 1/1, no error. Async reset asserted mid-stall -> all outputs 0 immediately.
